display_arbiter: RTL and testbench

Shares the 4-digit 7-segment display subsystem between two BCD producers: keypad operand echo (KB) and multiplier product (MUL).
Captures the granted source's 16-bit BCD word into a holding register and drives the display subsystem's BCD_code/valid_BCD inputs.
A freshly captured product is guaranteed a minimum on-screen time before keypad traffic may overwrite it.
Sits between the keypad/multiplier control paths and display_code.

---
 rtl/display_pkg.sv | 18 +
 rtl/display_arbiter_if.sv | 27 ++
 rtl/hold_timer.sv | 45 ++++
 rtl/display_arbiter.sv | 77 +++++++
 tb/tb_display_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types for the display arbiter: source and FSM encodings plus the BCD word width.
package display_pkg;

  localparam int BCD_W = 16;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_KB   = 2'b01,
    SRC_MUL  = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    BLANK,
    SHOW_KB,
    SHOW_MUL
  } arb_state_e;

endpackage

// File: rtl/display_arbiter_if.sv
// Producer and display-side signals of the display arbiter.
// The master side drives requests and clear. The slave side is the arbiter.
interface display_arbiter_if;
  import display_pkg::*;

  logic             clr;
  logic             kb_req;
  logic [BCD_W-1:0] kb_bcd;
  logic             kb_ack;
  logic             mul_req;
  logic [BCD_W-1:0] mul_bcd;
  logic             mul_ack;
  logic [BCD_W-1:0] bcd_code;
  logic             valid_bcd;
  src_e             active_src;
  logic             hold_busy;

  modport master (
    output clr, kb_req, kb_bcd, mul_req, mul_bcd,
    input  kb_ack, mul_ack, bcd_code, valid_bcd, active_src, hold_busy
  );

  modport slave (
    input  clr, kb_req, kb_bcd, mul_req, mul_bcd,
    output kb_ack, mul_ack, bcd_code, valid_bcd, active_src, hold_busy
  );
endinterface

// File: rtl/hold_timer.sv
// Minimum-display-time down-counter: load starts at HOLD_CYCLES-1 and saturates at 0.
// busy and expired_pulse are registered and track the counter value after each edge.
module hold_timer #(
  parameter int HOLD_CYCLES = 27_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_load,
  output logic o_busy,
  output logic o_expired_pulse
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;
  logic          r_busy;
  logic          r_expired;

  always_comb begin
    w_next = r_count;
    if (i_clr)
      w_next = '0;
    else if (i_load)
      w_next = CW'(HOLD_CYCLES - 1);
    else if (r_count != '0)
      w_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_next;
      r_busy    <= (w_next != '0);
      // Only a natural countdown counts as expiry; clear or reload does not.
      r_expired <= (r_count == CW'(1)) && !i_load && !i_clr;
    end
  end

  assign o_busy          = r_busy;
  assign o_expired_pulse = r_expired;
endmodule

// File: rtl/display_arbiter.sv
// Grants the 7-segment display to the MUL or KB producer and holds the captured word.
// A fresh MUL product locks KB out until the hold timer runs down.
module display_arbiter
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 27_000_000
) (
  input  logic              clk,
  input  logic              reset,
  display_arbiter_if.slave  bus
);
  arb_state_e       r_state;
  src_e             r_src;
  logic [BCD_W-1:0] r_bcd;
  logic             r_valid;
  logic             r_kb_ack;
  logic             r_mul_ack;

  logic w_hold_busy;
  logic w_hold_expired;
  logic w_kb_allowed;
  logic w_mul_grant;
  logic w_kb_grant;

  // A req is ignored while its own ack is out, so a slow deassert cannot double-capture.
  assign w_mul_grant  = !bus.clr && bus.mul_req && !r_mul_ack;
  assign w_kb_allowed = (r_state != SHOW_MUL) || !w_hold_busy || w_hold_expired;
  assign w_kb_grant   = !bus.clr && !w_mul_grant && bus.kb_req && !r_kb_ack && w_kb_allowed;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk             (clk),
    .reset           (reset),
    .i_clr           (bus.clr),
    .i_load          (w_mul_grant),
    .o_busy          (w_hold_busy),
    .o_expired_pulse (w_hold_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= BLANK;
      r_src     <= SRC_NONE;
      r_bcd     <= '0;
      r_valid   <= 1'b0;
      r_kb_ack  <= 1'b0;
      r_mul_ack <= 1'b0;
    end else begin
      r_kb_ack  <= w_kb_grant;
      r_mul_ack <= w_mul_grant;
      if (bus.clr) begin
        r_state <= BLANK;
        r_src   <= SRC_NONE;
        r_bcd   <= '0;
        r_valid <= 1'b0;
      end else if (w_mul_grant) begin
        r_state <= SHOW_MUL;
        r_src   <= SRC_MUL;
        r_bcd   <= bus.mul_bcd;
        r_valid <= 1'b1;
      end else if (w_kb_grant) begin
        r_state <= SHOW_KB;
        r_src   <= SRC_KB;
        r_bcd   <= bus.kb_bcd;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.kb_ack     = r_kb_ack;
  assign bus.mul_ack    = r_mul_ack;
  assign bus.bcd_code   = r_bcd;
  assign bus.valid_bcd  = r_valid;
  assign bus.active_src = r_src;
  assign bus.hold_busy  = w_hold_busy;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a cycle-level reference model and literal spot checks.
module tb_display_arbiter;
  localparam int HOLD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  display_arbiter_if bus();

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display word, owner and remaining hold time.
  logic [15:0] m_bcd = '0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_src = 2'b00;
  logic        m_kb_ack = 1'b0;
  logic        m_mul_ack = 1'b0;
  int          m_hold = 0;
  logic        m_mul_g, m_kb_g, m_kb_open;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bcd = '0; m_valid = 1'b0; m_src = 2'b00;
      m_kb_ack = 1'b0; m_mul_ack = 1'b0; m_hold = 0;
    end else begin
      m_kb_open = (m_src != 2'b10) || (m_hold == 0);
      m_mul_g   = !bus.clr && bus.mul_req && !m_mul_ack;
      m_kb_g    = !bus.clr && !m_mul_g && bus.kb_req && !m_kb_ack && m_kb_open;
      m_kb_ack  = m_kb_g;
      m_mul_ack = m_mul_g;
      if (bus.clr) begin
        m_bcd = '0; m_valid = 1'b0; m_src = 2'b00; m_hold = 0;
      end else if (m_mul_g) begin
        m_bcd = bus.mul_bcd; m_valid = 1'b1; m_src = 2'b10; m_hold = HOLD - 1;
      end else begin
        if (m_hold > 0) m_hold = m_hold - 1;
        if (m_kb_g) begin
          m_bcd = bus.kb_bcd; m_valid = 1'b1; m_src = 2'b01;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("m_bcd_code",   bus.bcd_code, m_bcd);
      check("m_valid_bcd",  {15'd0, bus.valid_bcd}, {15'd0, m_valid});
      check("m_active_src", {14'd0, bus.active_src}, {14'd0, m_src});
      check("m_kb_ack",     {15'd0, bus.kb_ack}, {15'd0, m_kb_ack});
      check("m_mul_ack",    {15'd0, bus.mul_ack}, {15'd0, m_mul_ack});
      check("m_hold_busy",  {15'd0, bus.hold_busy}, {15'd0, (m_hold != 0)});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int  busy_cnt, delay;
  bit  got, done;

  initial begin
    bus.clr = 1'b0; bus.kb_req = 1'b0; bus.kb_bcd = '0;
    bus.mul_req = 1'b0; bus.mul_bcd = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (20) tick();
    check("idle_bcd",   bus.bcd_code, 16'h0000);
    check("idle_valid", {15'd0, bus.valid_bcd}, 16'd0);
    check("idle_src",   {14'd0, bus.active_src}, 16'd0);

    // Single KB capture, req held through the ack cycle
    bus.kb_bcd = 16'h0042; bus.kb_req = 1'b1;
    tick();
    check("kb_bcd",   bus.bcd_code, 16'h0042);
    check("kb_valid", {15'd0, bus.valid_bcd}, 16'd1);
    check("kb_src",   {14'd0, bus.active_src}, 16'd1);
    check("kb_ack",   {15'd0, bus.kb_ack}, 16'd1);
    tick();
    check("kb_no_reack", {15'd0, bus.kb_ack}, 16'd0);
    bus.kb_req = 1'b0;
    tick();
    check("kb_ack_low", {15'd0, bus.kb_ack}, 16'd0);

    // Simultaneous requests: MUL first, KB after hold expiry
    bus.kb_bcd = 16'h0007; bus.mul_bcd = 16'h1234;
    bus.kb_req = 1'b1; bus.mul_req = 1'b1;
    tick();
    check("sim_mul_ack", {15'd0, bus.mul_ack}, 16'd1);
    check("sim_bcd",     bus.bcd_code, 16'h1234);
    check("sim_busy",    {15'd0, bus.hold_busy}, 16'd1);
    bus.mul_req = 1'b0;
    busy_cnt = 1; delay = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      delay++;
      if (bus.kb_ack) begin
        got = 1'b1;
        check("kb_ack_after_hold", {15'd0, bus.hold_busy}, 16'd0);
      end else if (bus.hold_busy) begin
        busy_cnt++;
      end
    end
    check("sim_kb_seen",   {15'd0, got}, 16'd1);
    check("sim_busy_cnt",  16'(busy_cnt), 16'd7);
    check("sim_kb_delay",  16'(delay), 16'd8);
    check("sim_kb_bcd",    bus.bcd_code, 16'h0007);
    bus.kb_req = 1'b0;
    tick();

    // MUL preempts KB, then a second MUL reloads the running timer
    bus.kb_bcd = 16'h0005; bus.kb_req = 1'b1;
    tick();
    check("pre_kb_bcd", bus.bcd_code, 16'h0005);
    bus.kb_req = 1'b0;
    tick();
    bus.mul_bcd = 16'h0081; bus.mul_req = 1'b1;
    tick();
    check("pre_mul_bcd", bus.bcd_code, 16'h0081);
    check("pre_mul_src", {14'd0, bus.active_src}, 16'd2);
    bus.mul_req = 1'b0;
    repeat (4) tick();
    bus.mul_bcd = 16'h0099; bus.mul_req = 1'b1;
    tick();
    check("reload_bcd", bus.bcd_code, 16'h0099);
    check("reload_ack", {15'd0, bus.mul_ack}, 16'd1);
    bus.mul_req = 1'b0;
    busy_cnt = 1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (bus.hold_busy) busy_cnt++;
      else done = 1'b1;
    end
    check("reload_busy_cnt", 16'(busy_cnt), 16'd7);

    // Clear beats a concurrent KB request, which is granted next cycle
    bus.clr = 1'b1; bus.kb_bcd = 16'h0011; bus.kb_req = 1'b1;
    tick();
    check("clr_valid",  {15'd0, bus.valid_bcd}, 16'd0);
    check("clr_bcd",    bus.bcd_code, 16'h0000);
    check("clr_src",    {14'd0, bus.active_src}, 16'd0);
    check("clr_no_ack", {15'd0, bus.kb_ack}, 16'd0);
    bus.clr = 1'b0;
    tick();
    check("post_clr_bcd", bus.bcd_code, 16'h0011);
    check("post_clr_ack", {15'd0, bus.kb_ack}, 16'd1);
    bus.kb_req = 1'b0;
    tick();

    // Non-decimal nibble passes through verbatim
    bus.kb_bcd = 16'h00A3; bus.kb_req = 1'b1;
    tick();
    check("hex_bcd",   bus.bcd_code, 16'h00A3);
    check("hex_valid", {15'd0, bus.valid_bcd}, 16'd1);
    bus.kb_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a MUL hold
    bus.mul_bcd = 16'h0456; bus.mul_req = 1'b1;
    tick();
    check("rst_pre_busy", {15'd0, bus.hold_busy}, 16'd1);
    bus.mul_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_bcd",   bus.bcd_code, 16'h0000);
    check("rst_valid", {15'd0, bus.valid_bcd}, 16'd0);
    check("rst_src",   {14'd0, bus.active_src}, 16'd0);
    check("rst_busy",  {15'd0, bus.hold_busy}, 16'd0);
    check("rst_mack",  {15'd0, bus.mul_ack}, 16'd0);
    bus.kb_bcd = 16'h0077; bus.kb_req = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_rst_ack", {15'd0, bus.kb_ack}, 16'd1);
    check("post_rst_bcd", bus.bcd_code, 16'h0077);
    bus.kb_req = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
